// File: rtl/rv32v_vmem_requester.sv
// Vector memory requester: splits one vector load/store command into NUM_LANES-wide
// beats towards the load-store controller and returns load data to the VRF.
// Optional feature macro: VMEM_WIDE_STORE_EN enables whole-block unit-stride word stores.
// load_type uses RISC-V funct3 encodings: LBU=3'b100, LHU=3'b101, LW=3'b010.
module rv32v_vmem_requester #(
    parameter int unsigned NUM_LANES         = 4,
    parameter int unsigned VL_W              = 9,
    parameter int unsigned DCACHE_BLOCK_SIZE = 4,
    parameter int unsigned WORD_SIZE         = 4
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                start,
    input  logic                                is_store,
    input  logic [31:0]                         base_addr,
    input  logic [31:0]                         stride,
    input  logic [1:0]                          eew,
    input  logic [VL_W-1:0]                     vl,
    input  logic [NUM_LANES*32-1:0]             vs_data,
    output logic [VL_W-1:0]                     elem_idx,
    output logic                                ren,
    output logic                                wen,
    output logic [NUM_LANES*32-1:0]             addr_wide,
    output logic [NUM_LANES-1:0]                ven_lanes,
    output logic [DCACHE_BLOCK_SIZE*32-1:0]     store_data_wide,
    output logic [DCACHE_BLOCK_SIZE*WORD_SIZE-1:0] store_en_wide,
    output logic                                wide_vstore,
    output logic [2:0]                          load_type,
    input  logic                                lsc_ready,
    input  logic [NUM_LANES*32-1:0]             dload_ext_wide,
    input  logic                                mal_addr,
    output logic                                wb_valid,
    output logic [VL_W-1:0]                     wb_idx,
    output logic [NUM_LANES*32-1:0]             wb_data,
    output logic [NUM_LANES-1:0]                wb_mask,
    output logic                                busy,
    output logic                                done,
    output logic                                fault,
    output logic [VL_W-1:0]                     fault_idx
);

    localparam logic [2:0] LdLbu = 3'b100;
    localparam logic [2:0] LdLhu = 3'b101;
    localparam logic [2:0] LdLw  = 3'b010;
    localparam int unsigned IdxW = VL_W + 1;
    // Lanes shared between the VRF read port and the cache block.
    localparam int unsigned StLanes = (NUM_LANES < DCACHE_BLOCK_SIZE) ? NUM_LANES
                                                                      : DCACHE_BLOCK_SIZE;

    typedef enum logic [1:0] {StIdle, StIssue, StDone, StFault} state_e;

    state_e                  state_q;
    logic                    is_store_q;
    logic [31:0]             stride_q;
    logic [31:0]             cur_base_q;
    logic [1:0]              eew_q;
    logic [VL_W-1:0]         vl_q;
    logic [VL_W-1:0]         elem_idx_q;
    logic                    ren_q, wen_q, busy_q, done_q, fault_q, wb_valid_q;
    logic [VL_W-1:0]         wb_idx_q, fault_idx_q;
    logic [NUM_LANES*32-1:0] wb_data_q;
    logic [NUM_LANES-1:0]    wb_mask_q;

    logic                    issuing;
    logic [IdxW-1:0]         next_idx;
    logic [31:0]             beat_stride;

    assign issuing     = (state_q == StIssue);
    // One bit wider than vl so the last beat of a large vl cannot wrap past it.
    assign next_idx    = {1'b0, elem_idx_q} + IdxW'(NUM_LANES);
    assign beat_stride = 32'(NUM_LANES) * stride_q;

    // Per-lane request fields, only driven while a beat is outstanding.
    always_comb begin
        addr_wide       = '0;
        ven_lanes       = '0;
        store_data_wide = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (issuing) begin
                addr_wide[i*32 +: 32] = cur_base_q + 32'(i) * stride_q;
                ven_lanes[i]          = ({1'b0, elem_idx_q} + IdxW'(i)) < {1'b0, vl_q};
            end
        end
        for (int i = 0; i < StLanes; i++) begin
            if (issuing) begin
                store_data_wide[i*32 +: 32] = vs_data[i*32 +: 32];
            end
        end
    end

    // Zero-extending load flavour follows the latched element width.
    always_comb begin
        case (eew_q)
            2'd0:    load_type = LdLbu;
            2'd1:    load_type = LdLhu;
            default: load_type = LdLw;
        endcase
    end

`ifdef VMEM_WIDE_STORE_EN
    localparam int unsigned BlkOffW = $clog2(DCACHE_BLOCK_SIZE * 4);

    if (NUM_LANES != DCACHE_BLOCK_SIZE) begin : g_bad_cfg
        $error("NUM_LANES must equal DCACHE_BLOCK_SIZE for wide vector stores");
    end

    logic wide_ok;
    // Word stores at unit word stride starting on a block boundary fill one cache block.
    assign wide_ok = issuing && is_store_q && (eew_q == 2'd2) && (stride_q == 32'd4) &&
                     (cur_base_q[BlkOffW-1:0] == '0);
    assign wide_vstore = wide_ok;

    // Byte enables cover every byte of each active lane.
    always_comb begin
        store_en_wide = '0;
        for (int i = 0; i < StLanes; i++) begin
            store_en_wide[i*WORD_SIZE +: WORD_SIZE] = {WORD_SIZE{wide_ok && ven_lanes[i]}};
        end
    end
`else
    assign wide_vstore   = 1'b0;
    assign store_en_wide = '0;
`endif

    // Command FSM with registered handshake, writeback and status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            is_store_q  <= 1'b0;
            stride_q    <= '0;
            cur_base_q  <= '0;
            eew_q       <= 2'd2;
            vl_q        <= '0;
            elem_idx_q  <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_idx_q    <= '0;
            wb_data_q   <= '0;
            wb_mask_q   <= '0;
            fault_idx_q <= '0;
        end else begin
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        is_store_q <= is_store;
                        stride_q   <= stride;
                        eew_q      <= (eew == 2'd3) ? 2'd2 : eew;
                        vl_q       <= vl;
                        cur_base_q <= base_addr;
                        elem_idx_q <= '0;
                        busy_q     <= 1'b1;
                        if (vl == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StIssue;
                            ren_q   <= !is_store;
                            wen_q   <= is_store;
                        end
                    end
                end
                StIssue: begin
                    if (mal_addr) begin
                        state_q     <= StFault;
                        fault_q     <= 1'b1;
                        fault_idx_q <= elem_idx_q;
                        ren_q       <= 1'b0;
                        wen_q       <= 1'b0;
                    end else if (lsc_ready) begin
                        if (!is_store_q) begin
                            wb_valid_q <= 1'b1;
                            wb_idx_q   <= elem_idx_q;
                            wb_data_q  <= dload_ext_wide;
                            wb_mask_q  <= ven_lanes;
                        end
                        elem_idx_q <= next_idx[VL_W-1:0];
                        cur_base_q <= cur_base_q + beat_stride;
                        if (next_idx >= {1'b0, vl_q}) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            ren_q   <= 1'b0;
                            wen_q   <= 1'b0;
                        end
                    end
                end
                StDone, StFault: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign elem_idx  = elem_idx_q;
    assign ren       = ren_q;
    assign wen       = wen_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign fault_idx = fault_idx_q;
    assign wb_valid  = wb_valid_q;
    assign wb_idx    = wb_idx_q;
    assign wb_data   = wb_data_q;
    assign wb_mask   = wb_mask_q;

endmodule

// File: tb/tb_rv32v_vmem_requester.sv
// Self-checking bench for rv32v_vmem_requester: directed vector table plus random commands
// checked against an element-level reference model.
module tb_rv32v_vmem_requester;

    localparam int N = 4;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;
    localparam logic [2:0] LT_LW  = 3'b010;
`ifdef VMEM_WIDE_STORE_EN
    localparam bit WideOn = 1'b1;
`else
    localparam bit WideOn = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         start, is_store, lsc_ready, mal_addr;
    logic [31:0]  base_addr, stride;
    logic [1:0]   eew;
    logic [8:0]   vl;
    logic [127:0] vs_data, dload_ext_wide;
    logic [8:0]   elem_idx, wb_idx, fault_idx;
    logic         ren, wen, wide_vstore, wb_valid, busy, done, fault;
    logic [127:0] addr_wide, store_data_wide, wb_data;
    logic [3:0]   ven_lanes, wb_mask;
    logic [15:0]  store_en_wide;
    logic [2:0]   load_type;

    int total;
    int bad;

    rv32v_vmem_requester dut (
        .CLK(CLK), .RST(RST), .start(start), .is_store(is_store), .base_addr(base_addr),
        .stride(stride), .eew(eew), .vl(vl), .vs_data(vs_data), .elem_idx(elem_idx),
        .ren(ren), .wen(wen), .addr_wide(addr_wide), .ven_lanes(ven_lanes),
        .store_data_wide(store_data_wide), .store_en_wide(store_en_wide),
        .wide_vstore(wide_vstore), .load_type(load_type), .lsc_ready(lsc_ready),
        .dload_ext_wide(dload_ext_wide), .mal_addr(mal_addr), .wb_valid(wb_valid),
        .wb_idx(wb_idx), .wb_data(wb_data), .wb_mask(wb_mask), .busy(busy), .done(done),
        .fault(fault), .fault_idx(fault_idx)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: everything derived from element number k = beat*N + lane.
    function automatic logic [127:0] m_addr(input logic [31:0] base, input logic [31:0] s,
                                            input int b);
        logic [127:0] r;
        for (int i = 0; i < N; i++) r[i*32 +: 32] = base + 32'(b * N + i) * s;
        return r;
    endfunction

    function automatic logic [3:0] m_ven(input int b, input int vlv);
        logic [3:0] r;
        for (int i = 0; i < N; i++) r[i] = (b * N + i) < vlv;
        return r;
    endfunction

    function automatic logic [2:0] m_lt(input logic [1:0] e);
        if (e == 2'd0) return LT_LBU;
        if (e == 2'd1) return LT_LHU;
        return LT_LW;
    endfunction

    function automatic bit m_wide(input bit st, input logic [1:0] e, input logic [31:0] s,
                                  input logic [31:0] base, input int b);
        logic [31:0] a;
        a = base + 32'(b * N) * s;
        return WideOn && st && (e >= 2'd2) && (s == 32'd4) && (a % 32'd16 == 0);
    endfunction

    function automatic logic [15:0] m_en(input bit w, input logic [3:0] v);
        logic [15:0] r;
        for (int i = 0; i < N; i++) r[i*4 +: 4] = (w && v[i]) ? 4'hF : 4'h0;
        return r;
    endfunction

    // Runs one command; dly<0 picks a random LSC latency per beat, fb>=0 faults that beat.
    task automatic run_cmd(input bit st, input logic [31:0] base, input logic [31:0] s,
                           input logic [1:0] e, input int vlv, input int fb, input int dly,
                           output logic [127:0] a0, output logic [3:0] v0,
                           output logic [2:0] lt0, output logic w0, output logic [15:0] en0,
                           output int nbeats, output logic flt);
        int nb, exp_b, b, d;
        bit exp_f, w;
        logic [127:0] dl, sd;
        logic [3:0] ev;
        nb    = (vlv + N - 1) / N;
        exp_f = (fb >= 0) && (fb < nb);
        exp_b = exp_f ? fb + 1 : nb;
        a0 = '0; v0 = '0; lt0 = '0; w0 = 1'b0; en0 = '0;
        is_store = st; base_addr = base; stride = s; eew = e; vl = 9'(vlv); start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        b = 0;
        while (b < 80) begin
            sd = {$urandom, $urandom, $urandom, $urandom};
            vs_data = sd;
            #1;
            if (!(ren || wen)) break;
            ev = m_ven(b, vlv);
            w  = m_wide(st, e, s, base, b);
            chk("beat_ren", ren, !st);
            chk("beat_wen", wen, st);
            chk("beat_elem_idx", elem_idx, b * N);
            chk("beat_addr", addr_wide, m_addr(base, s, b));
            chk("beat_ven", ven_lanes, ev);
            chk("beat_load_type", load_type, m_lt(e));
            chk("beat_busy", busy, 1);
            chk("beat_wide", wide_vstore, w);
            chk("beat_st_en", store_en_wide, m_en(w, ev));
            if (st) chk("beat_st_data", store_data_wide, sd);
            if (b == 0) begin
                a0 = addr_wide; v0 = ven_lanes; lt0 = load_type; w0 = wide_vstore;
                en0 = store_en_wide;
            end
            d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            for (int k = 0; k < d; k++) begin
                // Commands offered while busy must be ignored.
                if ($urandom_range(0, 2) == 0) begin
                    start = 1'b1; base_addr = $urandom; vl = 9'd1;
                end
                @(posedge CLK); #1;
                start = 1'b0;
                chk("wait_rw_hold", {ren, wen}, {!st, st});
                chk("wait_no_wb", wb_valid, 0);
            end
            dl = {$urandom, $urandom, $urandom, $urandom};
            dload_ext_wide = dl;
            lsc_ready = 1'b1;
            mal_addr  = (b == fb);
            @(posedge CLK); #1;
            lsc_ready = 1'b0;
            mal_addr  = 1'b0;
            if (!st && b != fb) begin
                chk("wb_valid", wb_valid, 1);
                chk("wb_idx", wb_idx, b * N);
                chk("wb_data", wb_data, dl);
                chk("wb_mask", wb_mask, ev);
            end else begin
                chk("wb_absent", wb_valid, 0);
            end
            b++;
        end
        nbeats = b;
        flt    = fault;
        chk("beat_count", b, exp_b);
        chk("done_pulse", done, !exp_f);
        chk("fault_pulse", fault, exp_f);
        chk("busy_at_end", busy, 1);
        if (exp_f) chk("fault_idx", fault_idx, fb * N);
        // A start during the done/fault cycle must not be taken.
        start = 1'b1; is_store = 1'b0; base_addr = 32'hDEAD_BEE0; vl = 9'd4;
        @(posedge CLK); #1;
        start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_fault", fault, 0);
        chk("idle_rw", {ren, wen}, 0);
        chk("idle_wb", wb_valid, 0);
    endtask

    typedef struct {
        bit           st;
        logic [31:0]  base;
        logic [31:0]  s;
        logic [1:0]   e;
        int           vlv;
        int           fb;
        logic [127:0] x_a0;
        logic [3:0]   x_v0;
        logic [2:0]   x_lt;
        logic         x_w;
        logic [15:0]  x_en;
        int           x_beats;
        logic         x_flt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [127:0] a0;
        logic [3:0]   v0;
        logic [2:0]   lt0;
        logic         w0, flt;
        logic [15:0]  en0;
        int           nbeats;
        bit           st;
        logic [1:0]   e;
        logic [31:0]  s, bs;
        int           vlv, fb;

        total = 0; bad = 0;
        RST = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0; stride = '0; eew = '0;
        vl = '0; vs_data = '0; lsc_ready = 1'b0; dload_ext_wide = '0; mal_addr = 1'b0;

        tbl[0] = '{1'b0, 32'h1000, 32'd4, 2'd2, 6, -1,
                   {32'h100C, 32'h1008, 32'h1004, 32'h1000}, 4'b1111, LT_LW, 1'b0, 16'h0,
                   2, 1'b0};
        tbl[1] = '{1'b1, 32'h2003, 32'hFFFF_FFFF, 2'd0, 3, -1,
                   {32'h2000, 32'h2001, 32'h2002, 32'h2003}, 4'b0111, LT_LBU, 1'b0, 16'h0,
                   1, 1'b0};
        tbl[2] = '{1'b1, 32'h2000, 32'd4, 2'd2, 0, -1, 128'h0, 4'b0000, LT_LW, 1'b0,
                   16'h0, 0, 1'b0};
        tbl[3] = '{1'b0, 32'h4000, 32'd4, 2'd2, 8, 1,
                   {32'h400C, 32'h4008, 32'h4004, 32'h4000}, 4'b1111, LT_LW, 1'b0, 16'h0,
                   2, 1'b1};
        tbl[4] = '{1'b1, 32'h3000, 32'd4, 2'd2, 4, -1,
                   {32'h300C, 32'h3008, 32'h3004, 32'h3000}, 4'b1111, LT_LW, WideOn,
                   WideOn ? 16'hFFFF : 16'h0, 1, 1'b0};
        tbl[5] = '{1'b1, 32'h3004, 32'd4, 2'd2, 4, -1,
                   {32'h3010, 32'h300C, 32'h3008, 32'h3004}, 4'b1111, LT_LW, 1'b0, 16'h0,
                   1, 1'b0};
        tbl[6] = '{1'b0, 32'h0100, 32'd2, 2'd3, 5, -1,
                   {32'h0106, 32'h0104, 32'h0102, 32'h0100}, 4'b1111, LT_LW, 1'b0, 16'h0,
                   2, 1'b0};
        tbl[7] = '{1'b0, 32'h0000, 32'd2, 2'd1, 256, -1,
                   {32'h0006, 32'h0004, 32'h0002, 32'h0000}, 4'b1111, LT_LHU, 1'b0, 16'h0,
                   64, 1'b0};
        tbl[8] = '{1'b1, 32'h8000, 32'hFFFF_FFFE, 2'd1, 1, 0,
                   {32'h7FFA, 32'h7FFC, 32'h7FFE, 32'h8000}, 4'b0001, LT_LHU, 1'b0, 16'h0,
                   1, 1'b1};

        // Reset state, before any clock edge.
        #2;
        chk("rst_ren", ren, 0);
        chk("rst_wen", wen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_elem_idx", elem_idx, 0);
        chk("rst_addr", addr_wide, 0);
        chk("rst_ven", ven_lanes, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_st_en", store_en_wide, 0);
        chk("rst_wide", wide_vstore, 0);
        chk("rst_load_type", load_type, LT_LW);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        for (int t = 0; t < 9; t++) begin
            run_cmd(tbl[t].st, tbl[t].base, tbl[t].s, tbl[t].e, tbl[t].vlv, tbl[t].fb, 2,
                    a0, v0, lt0, w0, en0, nbeats, flt);
            chk($sformatf("vec%0d_beats", t), nbeats, tbl[t].x_beats);
            chk($sformatf("vec%0d_fault", t), flt, tbl[t].x_flt);
            if (tbl[t].x_beats > 0) begin
                chk($sformatf("vec%0d_addr0", t), a0, tbl[t].x_a0);
                chk($sformatf("vec%0d_ven0", t), v0, tbl[t].x_v0);
                chk($sformatf("vec%0d_lt0", t), lt0, tbl[t].x_lt);
                chk($sformatf("vec%0d_wide0", t), w0, tbl[t].x_w);
                chk($sformatf("vec%0d_en0", t), en0, tbl[t].x_en);
            end
        end

        // Reset while a beat waits on the LSC: drop everything, no late writeback.
        is_store = 1'b0; base_addr = 32'h5000; stride = 32'd4; eew = 2'd2; vl = 9'd8;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk("prerst_ren", ren, 1);
        chk("prerst_busy", busy, 1);
        @(posedge CLK); #3;
        RST = 1'b1;
        #1;
        chk("asyncrst_ren", ren, 0);
        chk("asyncrst_wen", wen, 0);
        chk("asyncrst_busy", busy, 0);
        chk("asyncrst_elem_idx", elem_idx, 0);
        dload_ext_wide = {4{32'hA5A5_5A5A}};
        lsc_ready = 1'b1;
        @(posedge CLK); #1;
        chk("asyncrst_no_wb", wb_valid, 0);
        RST = 1'b0;
        @(posedge CLK); #1;
        lsc_ready = 1'b0;
        chk("postrst_no_wb", wb_valid, 0);
        chk("postrst_busy", busy, 0);
        chk("postrst_rw", {ren, wen}, 0);

        // Random commands against the model.
        for (int t = 0; t < 40; t++) begin
            st = 1'($urandom_range(0, 1));
            e  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       s = 32'd4;
                1:       s = 32'd1 << e;
                2:       s = 32'hFFFF_FFFC;
                3:       s = $urandom;
                default: s = 32'd0;
            endcase
            bs = $urandom;
            if ($urandom_range(0, 1) == 1) bs[3:0] = 4'h0;
            vlv = ($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(0, 20));
            fb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_cmd(st, bs, s, e, vlv, fb, -1, a0, v0, lt0, w0, en0, nbeats, flt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32v_vmem_requester.md
Name: rv32v_vmem_requester

Overview:
- Initiator side of the vector load-store controller interface.
- Accepts one vector memory command (base, stride, EEW, vl) from vector issue and splits it into NUM_LANES-wide beats.
- For each beat it drives ren/wen, addr_wide and ven_lanes, then waits on lsc_ready.
- Returns load data to the vector register file, and signals completion or a misaligned-address fault.

Parameters:
- NUM_LANES, 4, elements per beat; must equal DCACHE_BLOCK_SIZE when VMEM_WIDE_STORE_EN is defined (elaboration check).
- VL_W, 9, width of vl and element index (max vl 256).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- start  in  1  command valid; accepted only when busy=0.
- is_store  in  1  1=store, 0=load.
- base_addr  in  32  byte address of element 0.
- stride  in  32  byte stride between elements (two's complement).
- eew  in  2  0=8b, 1=16b, 2=32b; 3 is illegal and treated as 2.
- vl  in  VL_W  element count.
- vs_data  in  NUM_LANES*32  store data for elements elem_idx..elem_idx+NUM_LANES-1; combinational VRF read.
- elem_idx  out  VL_W  first element index of the current beat.
- ren  out  1  to LSC.
- wen  out  1  to LSC.
- addr_wide  out  NUM_LANES*32  to LSC.
- ven_lanes  out  NUM_LANES  to LSC.
- store_data_wide  out  DCACHE_BLOCK_SIZE*32  to LSC.
- store_en_wide  out  DCACHE_BLOCK_SIZE*WORD_SIZE  to LSC.
- wide_vstore  out  1  to LSC.
- load_type  out  load_t  to LSC.
- lsc_ready  in  1  LSC beat complete.
- dload_ext_wide  in  NUM_LANES*32  load data, valid with lsc_ready.
- mal_addr  in  1  LSC misaligned-address flag.
- wb_valid  out  1  writeback strobe.
- wb_idx  out  VL_W  writeback first element.
- wb_data  out  NUM_LANES*32  writeback data.
- wb_mask  out  NUM_LANES  writeback lane enables.
- busy  out  1  command in flight.
- done  out  1  one-cycle completion pulse.
- fault  out  1  one-cycle fault pulse.
- fault_idx  out  VL_W  elem_idx of the faulting beat.

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0, elem_idx=0, load_type=LW.
- Reset mid-command: the request is dropped immediately and no writeback is issued.
- FSM states: IDLE, ISSUE, DONE, FAULT.
- IDLE:
  - start=1 latches is_store, stride, eew, vl; cur_base <= base_addr; elem_idx <= 0; busy <= 1.
  - Next state is ISSUE, or DONE if vl==0 (no LSC request is made).
- ISSUE outputs:
  - ren = !is_store, wen = is_store; both held constant until lsc_ready.
  - addr_wide[i] = cur_base + i*stride, modulo 2^32.
  - ven_lanes[i] = (elem_idx+i < vl).
  - load_type: eew 0→LBU, 1→LHU, 2→LW.
  - store_data_wide lane i = vs_data lane i; store_en_wide = 0.
- ISSUE with mal_addr=1 (takes priority over lsc_ready): next state FAULT, fault_idx <= elem_idx, ren/wen deassert next cycle.
- ISSUE with lsc_ready=1:
  - Loads register a writeback: the next cycle has wb_valid=1, wb_idx=elem_idx, wb_data=dload_ext_wide, wb_mask=ven_lanes.
  - elem_idx += NUM_LANES; cur_base += NUM_LANES*stride.
  - If the new elem_idx >= vl, next state is DONE; otherwise stay in ISSUE and issue the next beat the following cycle with no idle bubble.
- Load latency: the writeback lands one cycle after its lsc_ready.
- DONE: done=1 for one cycle, busy <= 0, then IDLE. For a load, the final wb_valid and done are asserted in the same cycle.
- FAULT: fault=1 for one cycle, busy <= 0, then IDLE. The faulting beat is never written back.
- start while busy=1 is ignored. start in the same cycle done is high is also ignored; new commands are accepted only from IDLE.
- Element-count arithmetic: elem_idx and vl compare as unsigned VL_W. vl=256 with VL_W=9 completes after 256/NUM_LANES beats.

Optional Feature:
- VMEM_WIDE_STORE_EN defined:
  - Applies to a store with eew=2, stride==4, and cur_base aligned to DCACHE_BLOCK_SIZE*4 bytes.
  - Each such beat drives wide_vstore=1.
  - store_data_wide[i] = vs_data lane i.
  - store_en_wide has byte enables set for the bytes of active lanes (4 bits per active lane).
  - addr_wide[0] carries the block address.
  - Any beat that fails a condition falls back to per-lane mode.
- Not defined: wide_vstore and store_en_wide are tied 0.

Test Plan:
1. Unit-stride load: base=0x1000, stride=4, eew=2, vl=6, NUM_LANES=4, lsc_ready 2 cycles after each request.
   - Beat0 addr_wide=0x1000/04/08/0C, ven_lanes=1111; beat1 addr 0x1010/14/18/1C, ven_lanes=0011.
   - Two wb_valid pulses with wb_idx 0 and 4; done coincides with the second writeback.
2. Strided byte store: base=0x2003, stride=-1, eew=0, vl=3.
   - wen=1, load_type=LBU, addr_wide=0x2003/02/01/00, ven_lanes=0111.
   - One beat, done pulse, no wb_valid.
3. vl=0 store: start → done the cycle after acceptance, busy high for exactly one cycle, ren/wen never asserted.
4. mal_addr=1 on the second beat of vl=8: fault pulse with fault_idx=4, exactly one wb_valid (idx 0), no done; a new start is accepted in the next IDLE cycle.
5. RST asserted while ISSUE is waiting on lsc_ready: ren/wen/busy go 0 asynchronously and no wb_valid follows.
6. VMEM_WIDE_STORE_EN: store base=0x3000, eew=2, stride=4, vl=4 → single beat with wide_vstore=1 and store_en_wide=all ones (16 bits); with base=0x3004 → wide_vstore=0.
